// File: rtl/b16_uart.sv
// b16_uart: memory-mapped 8N1 UART for the b16 CPU data bus with one-byte TX holding and RX holding registers
// Ports: clk/nreset clock and async active-low reset; sel/addr/r/w/dwrite CPU bus cycle;
//        rdata read data (0 unless sel&r); txd/rxd serial lines; irq level interrupt request.
// Registers by addr[2:1]: 0 DATA, 1 STAT, 2 DIV, 3 reserved.
`timescale 1ns/1ps
module b16_uart #(
  parameter int l = 16,
  parameter logic [l-1:0] DIV_RESET = 16'd433
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         sel,
  input  logic [l-1:0] addr,
  input  logic         r,
  input  logic [1:0]   w,
  input  logic [l-1:0] dwrite,
  output logic [l-1:0] rdata,
  output logic         txd,
  input  logic         rxd,
  output logic         irq
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} st_t;
  st_t tx_st, tx_nxt, rx_st, rx_nxt;
  logic [l-1:0] div, eff_div, tx_cnt, rx_cnt;
  logic [7:0] tx_hold, tx_sh, tx_sh_n, rx_sh, rx_hold, stat;
  logic [2:0] tx_bit, rx_bit;
  logic tx_full, txd_n, tx_load, tx_done, rx_done;
  logic s1, s2, s3, rx_valid, rx_overrun, frame_err, ie_rx, ie_tx;
  logic pop, wr_data, wr_stat, wr_div, stop_ev, rx_good, rx_load;
  logic unused_addr;
  assign unused_addr = ^{addr[l-1:3], addr[0]};
  // Divisors below 3 would leave too few clocks per bit for the half-bit RX start check
  assign eff_div = div < l'(3) ? l'(3) : div;
  assign pop = sel & r & (addr[2:1] == 2'd0);
  // The holding register counts as empty on the edge it moves into the shifter
  assign wr_data = sel & w[0] & (addr[2:1] == 2'd0) & (!tx_full | tx_load);
  assign wr_stat = sel & w[0] & (addr[2:1] == 2'd1);
  assign wr_div = sel & (addr[2:1] == 2'd2);
  assign stat = {ie_tx, ie_rx, 1'b0, frame_err, rx_overrun, rx_valid, tx_st != IDLE, tx_full};
  assign rdata = !(sel & r) ? '0 :
                 addr[2:1] == 2'd0 ? l'(rx_hold) :
                 addr[2:1] == 2'd1 ? l'(stat) :
                 addr[2:1] == 2'd2 ? div : '0;
  assign tx_done = tx_cnt == '0;
  always_comb begin
    tx_nxt = tx_st;
    tx_sh_n = tx_sh;
    tx_load = 1'b0;
    case (tx_st)
      IDLE: begin
        tx_load = tx_full;
        tx_nxt = tx_full ? START : IDLE;
      end
      START: tx_nxt = tx_done ? DATA : START;
      DATA: begin
        tx_nxt = tx_done && tx_bit == 3'd7 ? STOP : DATA;
        tx_sh_n = tx_done ? tx_sh >> 1 : tx_sh;
      end
      default: begin
        tx_load = tx_done & tx_full;
        tx_nxt = tx_done ? (tx_full ? START : IDLE) : STOP;
      end
    endcase
    if (tx_load) tx_sh_n = tx_hold;
    txd_n = tx_nxt == START ? 1'b0 : tx_nxt == DATA ? tx_sh_n[0] : 1'b1;
  end
  assign rx_done = rx_cnt == '0;
  assign stop_ev = rx_st == STOP && rx_done;
  assign rx_good = stop_ev & s2;
  // A byte completing on the same edge as a pop replaces the popped one
  assign rx_load = rx_good & (!rx_valid | pop);
  always_comb begin
    rx_nxt = rx_st;
    case (rx_st)
      IDLE: rx_nxt = s3 & !s2 ? START : IDLE;
      START: rx_nxt = rx_done ? (s2 ? IDLE : DATA) : START;
      DATA: rx_nxt = rx_done && rx_bit == 3'd7 ? STOP : DATA;
      default: rx_nxt = rx_done ? IDLE : STOP;
    endcase
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tx_st <= IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh <= '0;
      tx_hold <= '0;
      tx_full <= 1'b0;
      txd <= 1'b1;
    end else begin
      tx_st <= tx_nxt;
      // Idle keeps the counter primed so START gets a full bit period
      tx_cnt <= tx_st == IDLE || tx_done ? eff_div : tx_cnt - 1'b1;
      tx_bit <= tx_st == START ? 3'd0 : tx_st == DATA && tx_done ? tx_bit + 3'd1 : tx_bit;
      tx_sh <= tx_sh_n;
      tx_hold <= wr_data ? dwrite[7:0] : tx_hold;
      tx_full <= wr_data | (tx_full & !tx_load);
      txd <= txd_n;
    end
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      {s1, s2, s3} <= 3'b111;
      rx_st <= IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
      rx_hold <= '0;
      rx_valid <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      {s1, s2, s3} <= {rxd, s1, s2};
      rx_st <= rx_nxt;
      // Idle preloads half a bit so START samples the middle of the start bit
      rx_cnt <= rx_st == IDLE ? eff_div >> 1 : rx_done ? eff_div : rx_cnt - 1'b1;
      rx_bit <= rx_st == START ? 3'd0 : rx_st == DATA && rx_done ? rx_bit + 3'd1 : rx_bit;
      rx_sh <= rx_st == DATA && rx_done ? {s2, rx_sh[7:1]} : rx_sh;
      rx_hold <= rx_load ? rx_sh : rx_hold;
      rx_valid <= rx_load | (rx_valid & !pop);
      rx_overrun <= rx_good & rx_valid & !pop ? 1'b1 : wr_stat & dwrite[3] ? 1'b0 : rx_overrun;
      frame_err <= stop_ev & !s2 ? 1'b1 : wr_stat & dwrite[4] ? 1'b0 : frame_err;
    end
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      div <= DIV_RESET;
      ie_rx <= 1'b0;
      ie_tx <= 1'b0;
      irq <= 1'b0;
    end else begin
      div[15:8] <= wr_div & w[1] ? dwrite[15:8] : div[15:8];
      div[7:0] <= wr_div & w[0] ? dwrite[7:0] : div[7:0];
      ie_rx <= wr_stat ? dwrite[6] : ie_rx;
      ie_tx <= wr_stat ? dwrite[7] : ie_tx;
      irq <= (ie_rx & rx_valid) | (ie_tx & !tx_full);
    end
  end
endmodule

// File: tb/tb_b16_uart.sv
// tb_b16_uart: scoreboard bench for b16_uart, TX frames decoded from txd and RX bytes checked on DATA reads
`timescale 1ns/1ps
module tb_b16_uart;
  logic clk = 1'b0, nreset = 1'b0, sel = 1'b0, r = 1'b0, rxd = 1'b1;
  logic [1:0] w = 2'b00;
  logic [15:0] addr = '0, dwrite = '0, rdata, d;
  logic txd, irq;
  int checks = 0, errors = 0;
  logic [7:0] tx_q[$], rx_q[$];
  logic [7:0] b;
  time ts, last_ts = 0, gap = 0;
  logic seen;
  b16_uart #(.DIV_RESET(16'd3)) dut (
    .clk(clk), .nreset(nreset), .sel(sel), .addr(addr), .r(r), .w(w),
    .dwrite(dwrite), .rdata(rdata), .txd(txd), .rxd(rxd), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic peek(input logic [1:0] a, output logic [15:0] v);
    sel = 1'b1; r = 1'b1; addr = {13'b0, a, 1'b0};
    #1 v = rdata;
    sel = 1'b0; r = 1'b0;
  endtask
  task automatic rd(input logic [1:0] a, output logic [15:0] v);
    sel = 1'b1; r = 1'b1; addr = {13'b0, a, 1'b0};
    #1 v = rdata;
    @(posedge clk); #1;
    sel = 1'b0; r = 1'b0;
  endtask
  task automatic wr(input logic [1:0] a, input logic [15:0] v, input logic [1:0] we);
    sel = 1'b1; w = we; addr = {13'b0, a, 1'b0}; dwrite = v;
    @(posedge clk); #1;
    sel = 1'b0; w = 2'b00;
  endtask
  task automatic send(input logic [7:0] v, input logic stop);
    rxd = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rxd = v[i];
      repeat (8) @(posedge clk);
      #1;
    end
    rxd = stop;
    repeat (8) @(posedge clk);
    #1;
    rxd = 1'b1;
  endtask
  task automatic tx_drain();
    for (int i = 0; i < 2000 && tx_q.size() != 0; i++) @(posedge clk);
    chk("tx_drain", 16'(tx_q.size()), 16'd0);
    repeat (20) @(posedge clk);
    #1;
  endtask
  // Decodes txd at 4 clocks per bit, sampling 2 ns after clock edges
  initial begin
    forever begin
      @(negedge txd);
      ts = $time;
      gap = ts - last_ts;
      last_ts = ts;
      #22;
      for (int i = 0; i < 8; i++) begin
        #40 b[i] = txd;
      end
      #40;
      chk("tx_stop", {15'b0, txd}, 16'd1);
      chk("tx_pending", 16'(tx_q.size() > 0), 16'd1);
      if (tx_q.size() > 0) chk("tx_byte", {8'h00, b}, {8'h00, tx_q.pop_front()});
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 nreset = 1'b1;
    chk("rst_txd", {15'b0, txd}, 16'd1);
    chk("rst_irq", {15'b0, irq}, 16'd0);
    peek(2'd2, d); chk("rst_div", d, 16'h0003);
    peek(2'd1, d); chk("rst_stat", d, 16'h0000);
    r = 1'b1; #1 chk("nosel_rdata", rdata, 16'h0000); r = 1'b0;
    @(posedge clk); #1;
    tx_q.push_back(8'hA5);
    wr(2'd0, 16'h00A5, 2'b01);
    chk("tx_pre", {15'b0, txd}, 16'd1);
    @(posedge clk); #1;
    chk("tx_startbit", {15'b0, txd}, 16'd0);
    peek(2'd1, d); chk("tx_full_clr", d & 16'h3, 16'h2);
    repeat (39) @(posedge clk);
    #1 peek(2'd1, d); chk("tx_busy39", d & 16'h2, 16'h2);
    @(posedge clk);
    #1 peek(2'd1, d); chk("tx_busy40", d & 16'h2, 16'h0);
    tx_drain();
    tx_q.push_back(8'h55);
    tx_q.push_back(8'h0F);
    wr(2'd0, 16'h0055, 2'b01);
    wr(2'd0, 16'h000F, 2'b01);
    wr(2'd0, 16'h0033, 2'b01);
    peek(2'd1, d); chk("tx_full_set", d & 16'h3, 16'h3);
    tx_drain();
    chk("b2b_gap", 16'(gap), 16'd400);
    wr(2'd2, 16'h0001, 2'b11);
    peek(2'd2, d); chk("div_small", d, 16'h0001);
    tx_q.push_back(8'hC3);
    wr(2'd0, 16'h00C3, 2'b01);
    tx_drain();
    wr(2'd2, 16'hAB07, 2'b01);
    peek(2'd2, d); chk("div_lowbyte", d, 16'h0007);
    sel = 1'b0; w = 2'b11; addr = 16'h0004; dwrite = 16'hFFFF;
    @(posedge clk); #1 w = 2'b00;
    peek(2'd2, d); chk("div_nosel", d, 16'h0007);
    wr(2'd3, 16'hFFFF, 2'b11);
    peek(2'd3, d); chk("reg3", d, 16'h0000);
    rx_q.push_back(8'h3C);
    send(8'h3C, 1'b1);
    peek(2'd1, d); chk("rx_valid", d & 16'h4, 16'h4);
    rd(2'd0, d); chk("rx_data", d, {8'h00, rx_q.pop_front()});
    peek(2'd1, d); chk("rx_popped", d & 16'h4, 16'h0);
    rx_q.push_back(8'h11);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    peek(2'd1, d); chk("rx_overrun", d & 16'h1C, 16'h0C);
    rd(2'd0, d); chk("ovr_data", d, {8'h00, rx_q.pop_front()});
    wr(2'd1, 16'h0008, 2'b01);
    peek(2'd1, d); chk("ovr_clr", d & 16'h1C, 16'h00);
    send(8'h5A, 1'b0);
    peek(2'd1, d); chk("frame_err", d & 16'h1C, 16'h10);
    wr(2'd1, 16'h0010, 2'b01);
    peek(2'd1, d); chk("ferr_clr", d, 16'h0000);
    rxd = 1'b0;
    @(posedge clk); #1 rxd = 1'b1;
    repeat (40) @(posedge clk);
    #1 peek(2'd1, d); chk("glitch", d, 16'h0000);
    wr(2'd1, 16'h0040, 2'b01);
    rx_q.push_back(8'hC5);
    seen = 1'b0;
    fork
      send(8'hC5, 1'b1);
      begin
        for (int i = 0; i < 200 && !seen; i++) begin
          @(posedge clk); #1 peek(2'd1, d);
          seen = d[2];
        end
        chk("irq_seen", {15'b0, seen}, 16'd1);
        chk("irq_lag", {15'b0, irq}, 16'd0);
        @(posedge clk); #1 chk("irq_rx", {15'b0, irq}, 16'd1);
      end
    join
    rd(2'd0, d); chk("irq_data", d, {8'h00, rx_q.pop_front()});
    @(posedge clk); #1 chk("irq_clr", {15'b0, irq}, 16'd0);
    wr(2'd1, 16'h0080, 2'b01);
    @(posedge clk); #1 chk("irq_tx", {15'b0, irq}, 16'd1);
    wr(2'd1, 16'h0000, 2'b01);
    @(posedge clk); #1 chk("irq_tx_off", {15'b0, irq}, 16'd0);
    wr(2'd0, 16'h0000, 2'b01);
    repeat (10) @(posedge clk);
    #1 chk("mid_txd", {15'b0, txd}, 16'd0);
    nreset = 1'b0;
    #1 chk("async_txd", {15'b0, txd}, 16'd1);
    peek(2'd1, d); chk("mid_rst_stat", d, 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
